// File: rtl/tx_frame_pkg.sv
// Shared types and constants for the TX frame builder and its CRC helper.
package tx_frame_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PRE,
      ADDR,
      LEN,
      PAYLOAD,
      CRC,
      FLUSH
   } state_e;

   localparam logic [15:0] CRC16_POLY   = 16'h1021;
   localparam logic [7:0]  DEF_PREAMBLE = 8'hAA;
   localparam logic [15:0] DEF_CRC_INIT = 16'hFFFF;

endpackage

// File: rtl/crc16_ccitt_byte.sv
// One byte of CRC-16/CCITT (poly 0x1021), MSB-first, no reflection.
module crc16_ccitt_byte
   import tx_frame_pkg::*;
(
   input  logic [15:0] crc_i,
   input  logic [7:0]  data_i,
   output logic [15:0] crc_o
);

   logic [15:0] c;

   // The whole data byte is folded into the top of the register up front,
   // then eight plain shift/XOR steps finish the division.
   always_comb begin
      c = crc_i ^ {data_i, 8'h00};
      for (int i = 0; i < 8; i++) begin
         c = c[15] ? ({c[14:0], 1'b0} ^ CRC16_POLY) : {c[14:0], 1'b0};
      end
      crc_o = c;
   end

endmodule

// File: rtl/tx_frame_builder.sv
// Builds preamble/address/length/payload/CRC frames and streams them
// back-to-back into the byte serializer.
module tx_frame_builder
   import tx_frame_pkg::*;
#(
   parameter logic [7:0]  PREAMBLE_BYTE = DEF_PREAMBLE,
   parameter int unsigned PREAMBLE_LEN  = 1,
   parameter logic [15:0] CRC_INIT      = DEF_CRC_INIT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        frame_start,
   input  logic [31:0] access_addr,
   input  logic [7:0]  pdu_len,
   input  logic [7:0]  pl_data,
   input  logic        pl_empty,
   output logic        pl_rd,
   input  logic        ser_ready,
   output logic        ser_start,
   output logic [7:0]  ser_data,
   output logic        busy,
   output logic        done,
   output logic        err_underrun
);

   localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_LEN - 1);

   state_e      state_q;
   logic [7:0]  cnt_q;
   logic [7:0]  len_q;
   logic [31:0] addr_q;
   logic [15:0] crc_q;
   logic [15:0] crc_nxt;
   logic [7:0]  crc_byte;
   logic        accept;
   logic        in_payload;

   assign in_payload = (state_q == PAYLOAD);
   assign crc_byte   = (state_q == LEN) ? len_q : pl_data;

   crc16_ccitt_byte u_crc (
      .crc_i  (crc_q),
      .data_i (crc_byte),
      .crc_o  (crc_nxt)
   );

   always_comb begin
      ser_start = 1'b0;
      ser_data  = 8'h00;
      unique case (state_q)
         PRE: begin
            ser_start = 1'b1;
            ser_data  = PREAMBLE_BYTE;
         end
         ADDR: begin
            ser_start = 1'b1;
            unique case (cnt_q[1:0])
               2'd0:    ser_data = addr_q[31:24];
               2'd1:    ser_data = addr_q[23:16];
               2'd2:    ser_data = addr_q[15:8];
               default: ser_data = addr_q[7:0];
            endcase
         end
         LEN: begin
            ser_start = 1'b1;
            ser_data  = len_q;
         end
         PAYLOAD: begin
            // Never offer a byte the FIFO does not actually hold.
            ser_start = ~pl_empty;
            ser_data  = pl_data;
         end
         CRC: begin
            ser_start = 1'b1;
            ser_data  = cnt_q[0] ? crc_q[7:0] : crc_q[15:8];
         end
         default: ;
      endcase
   end

   assign accept       = en & ser_ready & ser_start;
   assign pl_rd        = accept & in_payload;
   assign err_underrun = en & ser_ready & pl_empty & in_payload;
   assign done         = en & ser_ready & (state_q == FLUSH);
   assign busy         = (state_q != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 8'd0;
         len_q   <= 8'd0;
         addr_q  <= 32'd0;
         crc_q   <= CRC_INIT;
      end else if (en) begin
         unique case (state_q)
            IDLE: if (frame_start) begin
               state_q <= PRE;
               addr_q  <= access_addr;
               len_q   <= pdu_len;
               crc_q   <= CRC_INIT;
               cnt_q   <= 8'd0;
            end
            PRE: if (accept) begin
               if (cnt_q == PRE_LAST) begin
                  state_q <= ADDR;
                  cnt_q   <= 8'd0;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            ADDR: if (accept) begin
               if (cnt_q == 8'd3) begin
                  state_q <= LEN;
                  cnt_q   <= 8'd0;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            LEN: if (accept) begin
               crc_q   <= crc_nxt;
               state_q <= (len_q != 8'd0) ? PAYLOAD : CRC;
               cnt_q   <= 8'd0;
            end
            PAYLOAD: begin
               if (ser_ready && pl_empty) begin
                  state_q <= IDLE;
                  cnt_q   <= 8'd0;
               end else if (accept) begin
                  crc_q <= crc_nxt;
                  if (cnt_q == len_q - 8'd1) begin
                     state_q <= CRC;
                     cnt_q   <= 8'd0;
                  end else begin
                     cnt_q <= cnt_q + 8'd1;
                  end
               end
            end
            CRC: if (accept) begin
               if (cnt_q[0]) begin
                  state_q <= FLUSH;
                  cnt_q   <= 8'd0;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            FLUSH: if (ser_ready) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tx_frame_builder.sv
// Directed bench: frame vectors against a byte-level frame/CRC model, plus
// reset-mid-frame and request-while-busy sequences.
module tb_tx_frame_builder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        frame_start = 1'b0;
   logic [31:0] access_addr = 32'd0;
   logic [7:0]  pdu_len = 8'd0;
   logic [7:0]  pl_data = 8'd0;
   logic        pl_empty = 1'b1;
   logic        pl_rd;
   logic        ser_ready = 1'b0;
   logic        ser_start;
   logic [7:0]  ser_data;
   logic        busy, done, err_underrun;

   always #5 clk = ~clk;

   tx_frame_builder dut (
      .clk(clk), .rst(rst), .en(en), .frame_start(frame_start),
      .access_addr(access_addr), .pdu_len(pdu_len),
      .pl_data(pl_data), .pl_empty(pl_empty), .pl_rd(pl_rd),
      .ser_ready(ser_ready), .ser_start(ser_start), .ser_data(ser_data),
      .busy(busy), .done(done), .err_underrun(err_underrun)
   );

   typedef struct {
      logic [31:0] aa;
      logic [7:0]  len;
      int          nfifo;
      logic [7:0]  base;
      int          ediv;
      int          rdiv;
      int          pulse_at;
      bit          chk_crc;
      logic [15:0] crc_hand;
   } vec_t;

   logic [7:0] fifo[$];
   logic [7:0] cap[$];
   logic [7:0] exp_b[$];
   int checks = 0, errors = 0;
   int cyc = 0, en_div = 1, rdy_div = 1;
   bit pop_pend = 1'b0, skip_gap = 1'b0;
   int n_pop = 0, n_done = 0, n_err = 0, n_gap = 0, n_rd_noen = 0, exp_n = 0;

   // Cycle driver: FIFO pops, en / ready patterns, FWFT head.
   always @(posedge clk) begin
      #1;
      cyc++;
      if (pop_pend) begin
         if (fifo.size() > 0) void'(fifo.pop_front());
         pop_pend = 1'b0;
      end
      en        = (cyc % en_div) == 0;
      ser_ready = (cyc % rdy_div) == 0;
      pl_empty  = (fifo.size() == 0);
      pl_data   = pl_empty ? 8'h00 : fifo[0];
   end

   // Serializer model and event counters, sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst) begin
         if (en && ser_ready && ser_start) cap.push_back(ser_data);
         if (pl_rd) begin n_pop++; pop_pend = 1'b1; end
         if (pl_rd && !en) n_rd_noen++;
         if (done) n_done++;
         if (err_underrun) n_err++;
         if (busy && !ser_start && !skip_gap && cap.size() < exp_n) n_gap++;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
      logic [15:0] r;
      logic        fb;
      r = c;
      for (int i = 7; i >= 0; i--) begin
         fb = r[15] ^ b[i];
         r  = {r[14:0], 1'b0};
         if (fb) r = r ^ 16'h1021;
      end
      return r;
   endfunction

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic run_vec(input vec_t v, input string nm);
      logic [15:0] c;
      logic [7:0]  b;
      bit          under;
      int          k, bad, first_bad, npay;
      c = 16'hFFFF;
      exp_b.delete(); cap.delete(); fifo.delete();
      exp_b.push_back(8'hAA);
      for (int i = 3; i >= 0; i--) exp_b.push_back(v.aa[8*i +: 8]);
      exp_b.push_back(v.len);
      c = crc_upd(c, v.len);
      under = (v.nfifo < int'(v.len));
      npay  = under ? v.nfifo : int'(v.len);
      for (int i = 0; i < v.nfifo; i++) begin
         b = v.base + 8'(i);
         fifo.push_back(b);
         if (i < npay) begin
            exp_b.push_back(b);
            c = crc_upd(c, b);
         end
      end
      if (!under) begin
         exp_b.push_back(c[15:8]);
         exp_b.push_back(c[7:0]);
      end
      exp_n = exp_b.size();
      skip_gap = under;
      en_div = v.ediv; rdy_div = v.rdiv;
      n_pop = 0; n_done = 0; n_err = 0; n_gap = 0; n_rd_noen = 0;
      cycles(2);
      cap.delete();
      access_addr = v.aa; pdu_len = v.len; frame_start = 1'b1;
      k = 0;
      while (!busy && k < 50) begin cycles(1); k++; end
      frame_start = 1'b0;
      chk({nm, "_busy"}, {31'd0, busy}, 32'd1);
      access_addr = ~v.aa;
      k = 0;
      while (n_done == 0 && n_err == 0 && k < 4000) begin
         cycles(1);
         k++;
         if (v.pulse_at >= 0) frame_start = (cap.size() == v.pulse_at);
      end
      frame_start = 1'b0;
      chk({nm, "_timeout"}, {31'd0, k >= 4000}, 32'd0);
      cycles(6);
      chk({nm, "_nbytes"}, cap.size(), exp_n);
      bad = 0; first_bad = -1;
      for (int i = 0; i < exp_n && i < cap.size(); i++)
         if (cap[i] !== exp_b[i]) begin
            bad++;
            if (first_bad < 0) first_bad = i;
         end
      if (first_bad >= 0)
         $display("  %s first bad byte %0d: got %0h expected %0h", nm, first_bad,
                  cap[first_bad], exp_b[first_bad]);
      chk({nm, "_bad_bytes"}, bad, 0);
      if (v.chk_crc && cap.size() >= 2)
         chk({nm, "_crc_hand"}, {16'd0, cap[cap.size()-2], cap[cap.size()-1]}, {16'd0, v.crc_hand});
      chk({nm, "_pops"}, n_pop, npay);
      chk({nm, "_done"}, n_done, under ? 0 : 1);
      chk({nm, "_err"}, n_err, under ? 1 : 0);
      chk({nm, "_gaps"}, n_gap, 0);
      chk({nm, "_rd_noen"}, n_rd_noen, 0);
      chk({nm, "_fifo_left"}, fifo.size(), v.nfifo - npay);
      chk({nm, "_idle"}, {30'd0, busy, ser_start}, 32'd0);
   endtask

   vec_t vt[7];
   vec_t vr;
   int   k;

   initial begin
      vt[0] = '{32'h8E89BED6, 8'd0,   0,   8'h00, 1, 1, -1, 1'b1, 16'hE1F0};
      vt[1] = '{32'h8E89BED6, 8'd3,   3,   8'h01, 1, 1, -1, 1'b0, 16'h0000};
      vt[2] = '{32'h12345678, 8'd4,   2,   8'h10, 1, 1, -1, 1'b0, 16'h0000};
      vt[3] = '{32'hA5A5F00F, 8'd2,   2,   8'h33, 1, 1, -1, 1'b0, 16'h0000};
      vt[4] = '{32'hA5A5F00F, 8'd2,   2,   8'h33, 4, 1, -1, 1'b0, 16'h0000};
      vt[5] = '{32'h8E89BED6, 8'd3,   3,   8'h01, 1, 3, -1, 1'b0, 16'h0000};
      vt[6] = '{32'hCAFEBABE, 8'd255, 255, 8'h07, 1, 1, 20, 1'b0, 16'h0000};

      rst = 1'b1;
      cycles(3);
      chk("reset_outs", {21'd0, ser_start, ser_data, pl_rd, busy, done, err_underrun}, 32'd0);
      rst = 1'b0;
      cycles(1);

      for (int i = 0; i < 7; i++) run_vec(vt[i], $sformatf("vec%0d", i));

      // Reset while the address bytes are going out.
      en_div = 1; rdy_div = 1; skip_gap = 1'b1;
      fifo.delete(); fifo.push_back(8'h5A); fifo.push_back(8'h5B);
      n_pop = 0;
      cycles(2);
      cap.delete();
      access_addr = 32'h11223344; pdu_len = 8'd2; frame_start = 1'b1;
      k = 0;
      while (!busy && k < 50) begin cycles(1); k++; end
      frame_start = 1'b0;
      k = 0;
      while (cap.size() < 2 && k < 50) begin cycles(1); k++; end
      chk("rst_reach_addr", cap.size(), 2);
      rst = 1'b1;
      cycles(1);
      chk("rst_mid_outs", {21'd0, ser_start, ser_data, pl_rd, busy, done, err_underrun}, 32'd0);
      rst = 1'b0;
      cycles(1);
      chk("rst_no_pop", n_pop, 0);
      chk("rst_fifo_kept", fifo.size(), 2);
      vr = '{32'h11223344, 8'd2, 2, 8'h5A, 1, 1, -1, 1'b0, 16'h0000};
      run_vec(vr, "after_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
